// File: rtl/tlc_pkg.sv
// rtl/tlc_pkg.sv - shared phase codes, lamp codes, timing defaults and grant helper
package tlc_pkg;

    typedef enum logic [2:0] {
        PH_ALLRED   = 3'd0,
        PH_A_GREEN  = 3'd1,
        PH_A_YELLOW = 3'd2,
        PH_B_GREEN  = 3'd3,
        PH_B_YELLOW = 3'd4,
        PH_WALK     = 3'd5
    } phase_e;

    typedef enum logic [1:0] {
        SRV_A = 2'd0,
        SRV_B = 2'd1,
        SRV_P = 2'd2
    } served_e;

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    localparam int DEF_T_MIN_GREEN = 5;
    localparam int DEF_T_MAX_GREEN = 12;
    localparam int DEF_T_YELLOW    = 2;
    localparam int DEF_T_ALLRED    = 1;
    localparam int DEF_T_WALK      = 6;

    // Round-robin A->B->P starting after the last-served requester; idle grants A.
    function automatic phase_e rr_grant(input served_e last, input logic pa,
                                        input logic pb, input logic pp);
        phase_e g;
        g = PH_A_GREEN;
        case (last)
            SRV_A: begin
                if (pb)      g = PH_B_GREEN;
                else if (pp) g = PH_WALK;
                else         g = PH_A_GREEN;
            end
            SRV_B: begin
                if (pp)      g = PH_WALK;
                else if (pa) g = PH_A_GREEN;
                else if (pb) g = PH_B_GREEN;
                else         g = PH_A_GREEN;
            end
            default: begin
                if (pa)      g = PH_A_GREEN;
                else if (pb) g = PH_B_GREEN;
                else if (pp) g = PH_WALK;
                else         g = PH_A_GREEN;
            end
        endcase
        return g;
    endfunction

endpackage

// File: rtl/tlc_phase_timer.sv
// rtl/tlc_phase_timer.sv - 4-bit tick-enabled elapsed counter with clear, saturation and done compare
module tlc_phase_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       tick,
    input  logic [3:0] sat_val,
    input  logic [3:0] done_val,
    output logic [3:0] count,
    output logic       done
);

    logic [3:0] count_q;
    logic [3:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = 4'd0;
        end else if (tick && (count_q < sat_val)) begin
            count_d = count_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign done  = tick && (count_q == done_val);

endmodule

// File: rtl/intersection_phase_arbiter.sv
// rtl/intersection_phase_arbiter.sv - two-approach signal controller with pedestrian phase and round-robin grant
module intersection_phase_arbiter
    import tlc_pkg::*;
#(
    parameter int T_MIN_GREEN = DEF_T_MIN_GREEN,
    parameter int T_MAX_GREEN = DEF_T_MAX_GREEN,
    parameter int T_YELLOW    = DEF_T_YELLOW,
    parameter int T_ALLRED    = DEF_T_ALLRED,
    parameter int T_WALK      = DEF_T_WALK
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       Sa,
    input  logic       Sb,
    input  logic       ped_req,
    output logic [2:0] lightA,
    output logic [2:0] lightB,
    output logic       walk,
    output logic [2:0] state_disp
);

    phase_e     phase_q, phase_d;
    served_e    last_q, last_d;
    logic       pend_a_q, pend_a_d;
    logic       pend_b_q, pend_b_d;
    logic       pend_p_q, pend_p_d;

    logic [3:0] elapsed;
    logic       t_done;
    logic       t_clr;
    logic [3:0] sat_val;
    logic [3:0] done_val;
    logic [4:0] e_next;
    logic       min_ok;
    logic       max_ok;

    tlc_phase_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (t_clr),
        .tick     (tick),
        .sat_val  (sat_val),
        .done_val (done_val),
        .count    (elapsed),
        .done     (t_done)
    );

    // Green exit judges the elapsed count as it will be after this tick.
    assign e_next = {1'b0, elapsed} + 5'd1;
    assign min_ok = e_next >= 5'(T_MIN_GREEN);
    assign max_ok = e_next >= 5'(T_MAX_GREEN);

    always_comb begin
        sat_val  = 4'hF;
        done_val = 4'd0;
        case (phase_q)
            PH_ALLRED:                 done_val = 4'(T_ALLRED - 1);
            PH_A_YELLOW, PH_B_YELLOW:  done_val = 4'(T_YELLOW - 1);
            PH_WALK:                   done_val = 4'(T_WALK - 1);
            PH_A_GREEN, PH_B_GREEN:    sat_val  = 4'(T_MAX_GREEN);
            default:                   done_val = 4'd0;
        endcase
    end

    always_comb begin
        phase_d = phase_q;
        case (phase_q)
            PH_ALLRED: begin
                if (t_done) phase_d = rr_grant(last_q, pend_a_q, pend_b_q, pend_p_q);
            end
            PH_A_GREEN: begin
                if (tick && (pend_b_q || pend_p_q) && ((min_ok && !Sa) || max_ok))
                    phase_d = PH_A_YELLOW;
            end
            PH_A_YELLOW: begin
                if (t_done) phase_d = PH_ALLRED;
            end
            PH_B_GREEN: begin
                if (tick && (pend_a_q || pend_p_q) && ((min_ok && !Sb) || max_ok))
                    phase_d = PH_B_YELLOW;
            end
            PH_B_YELLOW: begin
                if (t_done) phase_d = PH_ALLRED;
            end
            PH_WALK: begin
                if (t_done) phase_d = PH_ALLRED;
            end
            default: phase_d = PH_ALLRED;
        endcase
    end

    assign t_clr = (phase_d != phase_q);

    // Entering a served phase clears its request even if the sensor is still high.
    always_comb begin
        pend_a_d = pend_a_q | Sa;
        pend_b_d = pend_b_q | Sb;
        pend_p_d = pend_p_q | (ped_req && (phase_q != PH_WALK));
        last_d   = last_q;
        if (t_clr && (phase_d == PH_A_GREEN)) begin
            pend_a_d = 1'b0;
            last_d   = SRV_A;
        end
        if (t_clr && (phase_d == PH_B_GREEN)) begin
            pend_b_d = 1'b0;
            last_d   = SRV_B;
        end
        if (t_clr && (phase_d == PH_WALK)) begin
            pend_p_d = 1'b0;
            last_d   = SRV_P;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q  <= PH_ALLRED;
            last_q   <= SRV_P;
            pend_a_q <= 1'b0;
            pend_b_q <= 1'b0;
            pend_p_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            last_q   <= last_d;
            pend_a_q <= pend_a_d;
            pend_b_q <= pend_b_d;
            pend_p_q <= pend_p_d;
        end
    end

    always_comb begin
        lightA = LAMP_R;
        lightB = LAMP_R;
        walk   = 1'b0;
        case (phase_q)
            PH_A_GREEN:  lightA = LAMP_G;
            PH_A_YELLOW: lightA = LAMP_Y;
            PH_B_GREEN:  lightB = LAMP_G;
            PH_B_YELLOW: lightB = LAMP_Y;
            PH_WALK:     walk   = 1'b1;
            default:     walk   = 1'b0;
        endcase
    end

    assign state_disp = phase_q;

endmodule

// File: tb/tb_intersection_phase_arbiter.sv
// tb/tb_intersection_phase_arbiter.sv - directed self-checking bench for intersection_phase_arbiter
module tb_intersection_phase_arbiter;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       Sa;
    logic       Sb;
    logic       ped_req;
    logic [2:0] lightA;
    logic [2:0] lightB;
    logic       walk;
    logic [2:0] state_disp;

    int n_checks = 0;
    int n_pass   = 0;

    intersection_phase_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .Sa         (Sa),
        .Sb         (Sb),
        .ped_req    (ped_req),
        .lightA     (lightA),
        .lightB     (lightB),
        .walk       (walk),
        .state_disp (state_disp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) pulse_tick();
    endtask

    task automatic pulse_in(input int which);
        if (which == 0) Sa = 1'b1;
        if (which == 1) Sb = 1'b1;
        if (which == 2) ped_req = 1'b1;
        @(posedge clk); #1;
        Sa = 1'b0; Sb = 1'b0; ped_req = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; tick = 1'b0; Sa = 1'b0; Sb = 1'b0; ped_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic chk_lamps(input string tag, input logic [2:0] st, input logic [2:0] la,
                             input logic [2:0] lb, input logic w);
        check({tag, "_state"}, 32'(state_disp), 32'(st));
        check({tag, "_lightA"}, 32'(lightA), 32'(la));
        check({tag, "_lightB"}, 32'(lightB), 32'(lb));
        check({tag, "_walk"}, 32'(walk), 32'(w));
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; Sa = 1'b0; Sb = 1'b0; ped_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_lamps("rst_during", 3'd0, 3'b100, 3'b100, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk_lamps("rst_after", 3'd0, 3'b100, 3'b100, 1'b0);

        // No requests: one all-red tick, then A rests in green.
        pulse_tick();
        chk_lamps("idle_agreen", 3'd1, 3'b001, 3'b100, 1'b0);
        ticks(25);
        check("idle_hold25", 32'(state_disp), 32'd1);
        ticks(25);
        chk_lamps("idle_hold50", 3'd1, 3'b001, 3'b100, 1'b0);
        check("idle_sat", 32'(dut.elapsed), 32'd12);

        // Gap-out: Sa=0, Sb pulsed at tick 0; same-clk Sb on B_GREEN entry.
        do_reset();
        pulse_tick();
        check("gap_entry", 32'(state_disp), 32'd1);
        pulse_in(1);
        check("gap_pendb", 32'(dut.pend_b_q), 32'd1);
        ticks(4);
        check("gap_t4", 32'(state_disp), 32'd1);
        pulse_tick();
        chk_lamps("gap_t5", 3'd2, 3'b010, 3'b100, 1'b0);
        pulse_tick();
        check("gap_t6", 32'(state_disp), 32'd2);
        pulse_tick();
        chk_lamps("gap_t7", 3'd0, 3'b100, 3'b100, 1'b0);
        Sb = 1'b1; tick = 1'b1;
        @(posedge clk); #1;
        Sb = 1'b0; tick = 1'b0;
        chk_lamps("gap_t8", 3'd3, 3'b100, 3'b001, 1'b0);
        check("same_clk_pendb", 32'(dut.pend_b_q), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("same_clk_pendb_later", 32'(dut.pend_b_q), 32'd0);

        // Max-out: Sa held high, Sb pulsed.
        do_reset();
        pulse_tick();
        Sa = 1'b1;
        pulse_in(1);
        Sa = 1'b1;
        ticks(11);
        check("max_t11", 32'(state_disp), 32'd1);
        pulse_tick();
        check("max_t12", 32'(state_disp), 32'd2);
        pulse_tick();
        check("max_t13", 32'(state_disp), 32'd2);
        pulse_tick();
        check("max_t14", 32'(state_disp), 32'd0);
        pulse_tick();
        check("max_t15_bgreen", 32'(state_disp), 32'd3);
        Sa = 1'b0;

        // Last served A with B and P pending: B first, then WALK.
        do_reset();
        pulse_tick();
        Sb = 1'b1; ped_req = 1'b1;
        @(posedge clk); #1;
        Sb = 1'b0; ped_req = 1'b0;
        ticks(7);
        check("rr_allred", 32'(state_disp), 32'd0);
        pulse_tick();
        check("rr_bgreen", 32'(state_disp), 32'd3);
        check("rr_pendp_kept", 32'(dut.pend_p_q), 32'd1);
        ticks(4);
        check("rr_b_t4", 32'(state_disp), 32'd3);
        pulse_tick();
        chk_lamps("rr_byellow", 3'd4, 3'b100, 3'b010, 1'b0);
        ticks(2);
        check("rr_allred2", 32'(state_disp), 32'd0);
        pulse_tick();
        chk_lamps("walk_entry", 3'd5, 3'b100, 3'b100, 1'b1);
        check("walk_pendp", 32'(dut.pend_p_q), 32'd0);
        ticks(5);
        chk_lamps("walk_t5", 3'd5, 3'b100, 3'b100, 1'b1);
        pulse_tick();
        chk_lamps("walk_exit", 3'd0, 3'b100, 3'b100, 1'b0);
        pulse_tick();
        check("walk_then_a", 32'(state_disp), 32'd1);

        // Reset asserted mid-WALK.
        do_reset();
        pulse_tick();
        pulse_in(2);
        ticks(7);
        pulse_tick();
        check("mid_walk_entry", 32'(state_disp), 32'd5);
        ticks(3);
        pulse_in(1);
        check("mid_walk_pendb", 32'(dut.pend_b_q), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_lamps("mid_walk_rst", 3'd0, 3'b100, 3'b100, 1'b0);
        check("mid_walk_rst_pendb", 32'(dut.pend_b_q), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        pulse_tick();
        check("mid_walk_next_a", 32'(state_disp), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/intersection_phase_arbiter.md
INTERSECTION_PHASE_ARBITER -- requirements
Module: intersection_phase_arbiter

Interface
REQ-001 SHALL have parameter T_MIN_GREEN, default 5, minimum green duration in ticks.
REQ-002 SHALL have parameter T_MAX_GREEN, default 12, maximum green duration in ticks while another request is pending.
REQ-003 SHALL have parameter T_YELLOW, default 2, yellow duration in ticks.
REQ-004 SHALL have parameter T_ALLRED, default 1, all-red clearance in ticks.
REQ-005 SHALL have parameter T_WALK, default 6, pedestrian walk duration in ticks.
REQ-006 SHALL have port clk, input, 1, single system clock; all state changes on posedge clk.
REQ-007 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-008 SHALL have port tick, input, 1, one-clk-wide timebase strobe (nominally 1 Hz).
REQ-009 SHALL have ports Sa and Sb, input, 1 each, vehicle presence sensors for approach A and approach B (level).
REQ-010 SHALL have port ped_req, input, 1, pedestrian button (any width pulse).
REQ-011 SHALL have ports lightA and lightB, output, 3 each, one-hot lamp code: R=100, Y=010, G=001.
REQ-012 SHALL have port walk, output, 1, pedestrian walk lamp.
REQ-013 SHALL have port state_disp, output, 3, current phase encoding.

Function
REQ-014 SHALL implement phases ALLRED=0, A_GREEN=1, A_YELLOW=2, B_GREEN=3, B_YELLOW=4, WALK=5; codes 6-7 SHALL recover to ALLRED on the next clk.
REQ-015 SHALL drive lights as follows: ALLRED R/R; A_GREEN G/R; A_YELLOW Y/R; B_GREEN R/G; B_YELLOW R/Y; WALK R/R with walk=1; walk=0 in every other phase.
REQ-016 SHALL latch requests each clk into sticky pend_A (Sa=1), pend_B (Sb=1), and pend_P (ped_req=1).
REQ-017 SHALL clear the pending bit of a requester on the clk it enters its green/WALK phase; clear wins over a same-cycle set; ped_req SHALL be ignored while in WALK.
REQ-018 SHALL hold an elapsed-tick counter, cleared on every phase entry and advanced only on clk edges with tick=1.
REQ-019 SHALL have timed phases (A_YELLOW, B_YELLOW, ALLRED, WALK) last exactly T ticks: exit on the tick where elapsed==T-1.
REQ-020 SHALL have green exit on a tick only if the other vehicle request or pend_P is pending, and either (e>=T_MIN_GREEN and own sensor=0) or e>=T_MAX_GREEN, where e=elapsed+1; otherwise green rests indefinitely, with elapsed saturating at T_MAX_GREEN.
REQ-021 SHALL sequence green->same-approach yellow->ALLRED, and WALK->ALLRED.
REQ-022 SHALL, on exit from ALLRED, grant round-robin among pending {A,B,P} in order A->B->P, starting after the last-served requester; if none is pending, it SHALL grant A.
REQ-023 SHALL update the last-served pointer on entry to A_GREEN, B_GREEN, or WALK.
REQ-024 SHALL make all outputs registered or a pure decode of registered state; no combinational path from inputs to outputs.
REQ-025 SHALL require 1<=T_*<=15 and T_MIN_GREEN<=T_MAX_GREEN; counter width SHALL be 4 bits.

Reset
REQ-026 SHALL, on rst=1 (async, including mid-phase), force phase=ALLRED, elapsed=0, all pend bits=0, and last-served=P.
REQ-027 SHALL present lightA=100, lightB=100, walk=0, and state_disp=0 during and immediately after reset.

Structure
REQ-028 SHALL place phase codes, lamp codes R/Y/G, and default timing constants in a shared package tlc_pkg.
REQ-029 SHALL instantiate one sub-module, tlc_phase_timer: a 4-bit tick-enabled counter with clear, saturation, and a done compare.

Verification
REQ-030 SHALL cover: reset, no requests, tick every 4 clk -> ALLRED for 1 tick, then A_GREEN held for 50 ticks.
REQ-031 SHALL cover: in A_GREEN with Sa=0, pulse Sb at tick 0 -> A_YELLOW after tick 5, ALLRED after tick 7, B_GREEN after tick 8.
REQ-032 SHALL cover: Sa held 1, Sb pulsed -> A_GREEN max-out at tick 12, then A_YELLOW 2 ticks.
REQ-033 SHALL cover: last-served A, pend_B and pend_P both set -> B_GREEN served, then WALK with walk=1 for 6 ticks, lights R/R.
REQ-034 SHALL cover: assert rst mid-WALK at tick 3 -> immediate R/R, walk=0, state_disp=0, pend cleared, next grant A.
REQ-035 SHALL cover: Sb asserted the same clk B_GREEN is entered -> pend_B=0 afterwards.
